// File: rtl/alu_pkg.sv
// Shared opcode, select and control definitions for the ALU issue/retire wrapper.
// Imported by alu_op_decode and alu_issue_stage.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] select;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_NOP = '0;

  function automatic alu_ctrl_t mk_ctrl(input logic ainv, input logic binv,
                                        input logic cin, input logic [1:0] sel);
    alu_ctrl_t c;
    c.ainv   = ainv;
    c.binv   = binv;
    c.cin    = cin;
    c.select = sel;
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> ALU controls plus SLT and illegal tags.
// Illegal opcodes decode to all-zero controls so the ALU sees a harmless AND.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] in_op,
  output alu_ctrl_t  ctrl,
  output logic       is_slt,
  output logic       err
);

  always_comb begin
    ctrl   = CTRL_NOP;
    is_slt = 1'b0;
    err    = 1'b0;
    case (in_op)
      OP_AND:  ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, SEL_AND);
      OP_OR:   ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, SEL_OR);
      OP_ADD:  ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, SEL_ADD);
      OP_SUB:  ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, SEL_ADD);
      OP_SLT: begin
        ctrl   = mk_ctrl(1'b0, 1'b1, 1'b1, SEL_ADD);
        is_slt = 1'b1;
      end
      OP_NOR:  ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, SEL_AND);
      OP_NAND: ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, SEL_OR);
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around an external combinational ALU.
// Stage 1 drives registered operands/controls to the ALU; stage 2 captures its result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_ainv,
  output logic         alu_binv,
  output logic         alu_cin,
  output logic [1:0]   alu_select,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_cout,
  output logic         out_overflow,
  output logic         out_zero,
  output logic         out_err
);

  alu_ctrl_t dec_ctrl;
  logic      dec_is_slt;
  logic      dec_err;

  alu_op_decode u_dec (
    .in_op  (in_op),
    .ctrl   (dec_ctrl),
    .is_slt (dec_is_slt),
    .err    (dec_err)
  );

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_a_q, s1_a_d;
  logic [N-1:0] s1_b_q, s1_b_d;
  alu_ctrl_t    s1_ctrl_q, s1_ctrl_d;
  logic         s1_is_slt_q, s1_is_slt_d;
  logic         s1_err_q, s1_err_d;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic         out_cout_q, out_cout_d;
  logic         out_overflow_q, out_overflow_d;
  logic         out_zero_q, out_zero_d;
  logic         out_err_q, out_err_d;

  logic         s1_adv;
  logic         accept;
  logic         slt_bit;
  logic [N-1:0] slt_result;

  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  // Signed less-than from the subtraction: sign bit corrected by overflow.
  assign slt_bit    = alu_result[N-1] ^ alu_overflow;
  assign slt_result = {{(N-1){1'b0}}, slt_bit};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_is_slt_d = s1_is_slt_q;
    s1_err_d    = s1_err_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_ctrl_d   = dec_ctrl;
      s1_is_slt_d = dec_is_slt;
      s1_err_d    = dec_err;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_cout_d     = out_cout_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    out_err_d      = out_err_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_err_q) begin
          out_result_d   = '0;
          out_cout_d     = 1'b0;
          out_overflow_d = 1'b0;
          out_zero_d     = 1'b0;
          out_err_d      = 1'b1;
        end else if (s1_is_slt_q) begin
          out_result_d   = slt_result;
          out_cout_d     = alu_cout;
          out_overflow_d = alu_overflow;
          out_zero_d     = !slt_bit;
          out_err_d      = 1'b0;
        end else begin
          out_result_d   = alu_result;
          out_cout_d     = alu_cout;
          out_overflow_d = alu_overflow;
          out_zero_d     = alu_zero;
          out_err_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_ctrl_q      <= CTRL_NOP;
      s1_is_slt_q    <= 1'b0;
      s1_err_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_cout_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_err_q      <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      s1_ctrl_q      <= s1_ctrl_d;
      s1_is_slt_q    <= s1_is_slt_d;
      s1_err_q       <= s1_err_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_cout_q     <= out_cout_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
      out_err_q      <= out_err_d;
    end
  end

  assign alu_a        = s1_a_q;
  assign alu_b        = s1_b_q;
  assign alu_ainv     = s1_ctrl_q.ainv;
  assign alu_binv     = s1_ctrl_q.binv;
  assign alu_cin      = s1_ctrl_q.cin;
  assign alu_select   = s1_ctrl_q.select;

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_cout     = out_cout_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_err      = out_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, arithmetic scoreboard model,
// per-cycle compare process and directed literal checks.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'd0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_ainv, alu_binv, alu_cin;
  logic [1:0]   alu_select;
  logic [N-1:0] alu_result;
  logic         alu_cout, alu_overflow, alu_zero;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_result;
  logic         out_cout, out_overflow, out_zero, out_err;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(alu_ainv), .alu_binv(alu_binv),
    .alu_cin(alu_cin), .alu_select(alu_select),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_err(out_err)
  );

  // Behavioural stand-in for n_bit_alu; flags only meaningful on the adder path.
  always_comb begin
    logic [N-1:0] aa, bb;
    logic [N:0]   s;
    aa = alu_ainv ? ~alu_a : alu_a;
    bb = alu_binv ? ~alu_b : alu_b;
    s  = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, alu_cin};
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_select)
      2'b00: alu_result = aa & bb;
      2'b01: alu_result = aa | bb;
      2'b10: begin
        alu_result   = s[N-1:0];
        alu_cout     = s[N];
        alu_overflow = (aa[N-1] == bb[N-1]) && (s[N-1] != aa[N-1]);
      end
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct packed {
    logic [N-1:0] r;
    logic c, v, z, e;
  } exp_t;

  function automatic logic ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int ia, ib;
    longint sa, sb;
    logic [N:0] u;
    e  = '0;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    case (op)
      OP_AND:  e.r = a & b;
      OP_OR:   e.r = a | b;
      OP_NOR:  e.r = ~(a | b);
      OP_NAND: e.r = ~(a & b);
      OP_ADD: begin
        u   = {1'b0, a} + {1'b0, b};
        e.r = u[N-1:0];
        e.c = u[N];
        e.v = ovf32(sa + sb);
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = ovf32(sa - sb);
      end
      OP_SLT: begin
        e.r = (sa < sb) ? 32'd1 : 32'd0;
        e.c = (a >= b);
        e.v = ovf32(sa - sb);
      end
      default: e.e = 1'b1;
    endcase
    e.z = !e.e && (e.r == '0);
    return e;
  endfunction

  int cmp_cnt = 0;
  int err_cnt = 0;
  int retired_cnt = 0;
  exp_t exp_q[$];
  exp_t last_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: sampled mid-cycle, inputs and outputs are stable here.
  logic         hold_pending = 1'b0;
  logic [N+4:0] hold_snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !(exp_q.size() == 2 && !out_ready)});
      if (hold_pending)
        chk("bp_hold", {58'd0, out_valid, out_result, out_cout, out_overflow, out_zero, out_err},
            {58'd0, hold_snap});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_retire", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("retire", {28'd0, out_result, out_cout, out_overflow, out_zero, out_err},
              {28'd0, e});
          last_ret.r = out_result;
          last_ret.c = out_cout;
          last_ret.v = out_overflow;
          last_ret.z = out_zero;
          last_ret.e = out_err;
          retired_cnt++;
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_snap    = {out_valid, out_result, out_cout, out_overflow, out_zero, out_err};
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
    end
  end

  // Called just after a rising edge; leaves in_valid high just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_retire(input int target);
    for (int k = 0; k < 40 && retired_cnt < target; k++) begin
      @(negedge clk);
      #2;
    end
    if (retired_cnt < target) chk("retire_timeout", retired_cnt, target);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input exp_t want);
    int base;
    base = retired_cnt;
    issue(op, a, b);
    in_valid = 1'b0;
    wait_retire(base + 1);
    chk(name, {28'd0, last_ret}, {28'd0, want});
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t lit(input logic [N-1:0] r, input logic c, input logic v,
                               input logic z, input logic e);
    exp_t x;
    x.r = r; x.c = c; x.v = v; x.z = z; x.e = e;
    return x;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_alu"}, {alu_a, alu_b}, 64'd0);
    chk({tag, "_alu_ctrl"}, {59'd0, alu_ainv, alu_binv, alu_cin, alu_select}, 64'd0);
    chk({tag, "_out"}, {28'd0, out_result, out_cout, out_overflow, out_zero, out_err}, 64'd0);
  endtask

  logic stream_done = 1'b0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept edge E0, out_valid low after E0, high after E1.
    issue(OP_ADD, 32'd5, 32'd6);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_e0_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_e1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("add_5_6", {28'd0, out_result, out_cout, out_overflow, out_zero, out_err},
        {28'd0, lit(32'd11, 1'b0, 1'b0, 1'b0, 1'b0)});
    @(posedge clk);
    #1;

    run_op("sub_7_7",    OP_SUB,  32'd7, 32'd7,                 lit(32'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    run_op("sub_min_1",  OP_SUB,  32'h8000_0000, 32'd1,         lit(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));
    run_op("slt_m1_1",   OP_SLT,  32'hFFFF_FFFF, 32'd1,         lit(32'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    run_op("slt_max_min", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, lit(32'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    run_op("nor_5_6",    OP_NOR,  32'd5, 32'd6,                 lit(32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0));
    run_op("nand_5_6",   OP_NAND, 32'd5, 32'd6,                 lit(32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b0));
    run_op("and_5_6",    OP_AND,  32'd5, 32'd6,                 lit(32'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    run_op("or_5_6",     OP_OR,   32'd5, 32'd6,                 lit(32'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    run_op("illegal_f",  4'b1111, 32'd5, 32'd6,                 lit(32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    run_op("add_wrap",   OP_ADD,  32'hFFFF_FFFF, 32'd1,         lit(32'd0, 1'b1, 1'b0, 1'b1, 1'b0));

    // Back-to-back stream under random backpressure; scoreboard checks order.
    begin
      int base;
      base = retired_cnt;
      fork
        begin
          while (!stream_done) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
        begin
          for (int i = 0; i < 8; i++)
            issue(OP_ADD, 32'(i * 3 + 1), 32'(i * 1000 + 32'hFFFF_0000));
          in_valid = 1'b0;
          stream_done = 1'b1;
        end
      join
      out_ready = 1'b1;
      wait_retire(base + 8);
      chk("stream_count", retired_cnt - base, 64'd8);
      chk("stream_drained", exp_q.size(), 64'd0);
    end
    @(posedge clk);
    #1;

    // Fill both stages under backpressure, then reset with in_valid still high.
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2);
    issue(OP_ADD, 32'd3, 32'd4);
    in_op = OP_OR;
    in_a  = 32'd9;
    in_b  = 32'd10;
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_out_head", {32'd0, out_result}, 64'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("mid");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_reset_add", OP_ADD, 32'd9, 32'd9, lit(32'd18, 1'b0, 1'b0, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
